// File: rtl/clkgen_pkg.sv
// Shared constants for the board-clock dividers.
// Holds the default counter width, the default sub-segment exponent and the
// half-period lengths for the common 50 MHz board rates. These are selected
// through default_half().
package clkgen_pkg;

  localparam int CNT_W_DEF    = 26;
  localparam int SUB_LOG2_DEF = 2;

  // Half-periods in 50 MHz clk cycles.
  localparam int HALF_1S     = 25_000_000;
  localparam int HALF_500MS  = 12_500_000;
  localparam int HALF_250MS  = 6_250_000;

  typedef enum logic [1:0] {
    RATE_1S    = 2'd0,
    RATE_500MS = 2'd1,
    RATE_250MS = 2'd2
  } rate_e;

  function automatic int default_half(input rate_e rate);
    case (rate)
      RATE_500MS: return HALF_500MS;
      RATE_250MS: return HALF_250MS;
      default:    return HALF_1S;
    endcase
  endfunction

endpackage

// File: rtl/multi_real_clock_gen_if.sv
// Configuration bus of multi_real_clock_gen.
//   cfg_valid : request present
//   cfg_ch    : target channel of the request
//   cfg_half  : requested half-period in clk cycles
//   cfg_ready : request may be taken this cycle
//   cfg_err   : one-cycle pulse after a rejected request
// The master modport belongs to the requester and the slave modport belongs to the divider.
interface multi_real_clock_gen_if #(
  parameter int CH_W  = 1,
  parameter int CNT_W = clkgen_pkg::CNT_W_DEF
);

  logic             cfg_valid;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_half;
  logic             cfg_ready;
  logic             cfg_err;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_half,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_half,
    output cfg_ready,
    output cfg_err
  );

endinterface

// File: rtl/clk_gen_channel.sv
// One divided-clock channel.
// Ports:
//   clk, reset   : board clock, asynchronous active-low reset
//   enable       : run enable; low clears the phase and forces the outputs low
//   cfg_we       : accepted configuration write for this channel
//   cfg_half     : written half-period
//   pending      : a shadowed half-period waits for the next main wrap
//   usr_clk      : divided clock with 50% duty
//   sub_clk      : toggles once per segment. There are 2^SUB_LOG2 segments per half-period.
//   tick         : one-cycle pulse in the cycle usr_clk rises
module clk_gen_channel #(
  parameter int CNT_W        = 26,
  parameter int DEFAULT_HALF = 25_000_000,
  parameter int SUB_LOG2     = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             pending,
  output logic             usr_clk,
  output logic             sub_clk,
  output logic             tick
);

  localparam int                 NSEG     = 2 ** SUB_LOG2;
  localparam int                 IDX_W    = SUB_LOG2 + 1;
  localparam logic [IDX_W-1:0]   LAST_SEG = IDX_W'(NSEG - 1);
  localparam logic [CNT_W-1:0]   RST_HALF = CNT_W'(DEFAULT_HALF);
  localparam logic [CNT_W-1:0]   ONE      = CNT_W'(1);

  logic [CNT_W-1:0] half_len;
  logic [CNT_W-1:0] shadow;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] seg_cnt;
  logic [CNT_W-1:0] seg_len;
  logic [IDX_W-1:0] seg_idx;
  logic             main_wrap;
  logic             seg_wrap;
  logic             last_seg;

  // The reject rule keeps half_len >= 2^SUB_LOG2. Therefore seg_len >= 1, and
  // neither subtraction below can underflow.
  assign seg_len   = half_len >> SUB_LOG2;
  assign main_wrap = (cnt == half_len - ONE);
  assign last_seg  = (seg_idx == LAST_SEG);
  // The last segment never wraps on its own. It runs on to the main wrap, which
  // absorbs any remainder.
  assign seg_wrap  = (seg_cnt == seg_len - ONE) && !last_seg;

  // The shadow only holds data. It is meaningful only while pending is set.
  always_ff @(posedge clk) begin
    if (cfg_we && enable) begin
      shadow <= cfg_half;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      half_len <= RST_HALF;
      pending  <= 1'b0;
      cnt      <= '0;
      seg_cnt  <= '0;
      seg_idx  <= '0;
      usr_clk  <= 1'b0;
      sub_clk  <= 1'b0;
      tick     <= 1'b0;
    end else begin
      // Length update. While the channel is stopped, a write or a waiting shadow
      // takes effect at once. While the channel runs, a shadow takes effect only
      // at a main wrap, and that wrap still uses the old length. cfg_we and
      // pending never coincide, because cfg_ready requires pending == 0.
      if (cfg_we && !enable) begin
        half_len <= cfg_half;
      end else if (pending && (!enable || main_wrap)) begin
        half_len <= shadow;
        pending  <= 1'b0;
      end
      if (cfg_we && enable) begin
        pending <= 1'b1;
      end

      // Phase and outputs
      if (!enable) begin
        cnt     <= '0;
        seg_cnt <= '0;
        seg_idx <= '0;
        usr_clk <= 1'b0;
        sub_clk <= 1'b0;
        tick    <= 1'b0;
      end else if (main_wrap) begin
        cnt     <= '0;
        seg_cnt <= '0;
        seg_idx <= '0;
        usr_clk <= ~usr_clk;
        sub_clk <= 1'b0;
        tick    <= ~usr_clk;
      end else begin
        cnt  <= cnt + ONE;
        tick <= 1'b0;
        if (seg_wrap) begin
          seg_cnt <= '0;
          seg_idx <= seg_idx + IDX_W'(1);
          sub_clk <= ~sub_clk;
        end else if (!last_seg) begin
          seg_cnt <= seg_cnt + ONE;
        end
      end
    end
  end

endmodule

// File: rtl/multi_real_clock_gen.sv
// Generates NUM_CH independent divided clocks from the board clock.
// Each channel has a programmable half-period, a sub-clock and a rise tick.
// Ports:
//   clk, reset : board clock, asynchronous active-low reset
//   enable     : per-channel run enable
//   cfg        : configuration bus (slave side): valid/ch/half in, ready/err out
//   usr_clk    : per-channel divided clock
//   sub_clk    : per-channel sub-clock at 2^SUB_LOG2 times the channel frequency
//   tick       : per-channel one-cycle pulse on the rising edge of usr_clk
module multi_real_clock_gen
  import clkgen_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int DEFAULT_HALF = default_half(RATE_1S),
  parameter int SUB_LOG2     = SUB_LOG2_DEF,
  parameter int CH_W         = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_CH-1:0]     enable,
  multi_real_clock_gen_if.slave cfg,
  output logic [NUM_CH-1:0]     usr_clk,
  output logic [NUM_CH-1:0]     sub_clk,
  output logic [NUM_CH-1:0]     tick
);

  localparam int               NCH_PAD  = 2 ** CH_W;
  localparam logic [CH_W:0]    NUM_CH_L = (CH_W + 1)'(NUM_CH);
  localparam logic [CNT_W-1:0] MIN_HALF = CNT_W'(2 ** SUB_LOG2);

  logic [NUM_CH-1:0]  pending;
  logic [NCH_PAD-1:0] pending_pad;
  logic               bad_ch;
  logic               bad_half;
  logic               accept;
  logic               err_d;

  // Pad pending to the full cfg_ch range. An out-of-range channel then selects
  // a defined bit. bad_ch still masks that case.
  assign pending_pad   = NCH_PAD'(pending);
  assign bad_ch        = ({1'b0, cfg.cfg_ch} >= NUM_CH_L);
  assign bad_half      = (cfg.cfg_half < MIN_HALF);
  assign cfg.cfg_ready = ~pending_pad[cfg.cfg_ch] & ~bad_ch;

  // A bad channel is reported even though ready is low. A bad half-period is
  // reported only when the request would otherwise have been taken.
  assign accept = cfg.cfg_valid & cfg.cfg_ready & ~bad_half;
  assign err_d  = cfg.cfg_valid & (bad_ch | (cfg.cfg_ready & bad_half));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg.cfg_err <= 1'b0;
    end else begin
      cfg.cfg_err <= err_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic cfg_we;
    assign cfg_we = accept & (cfg.cfg_ch == CH_W'(i));

    clk_gen_channel #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEFAULT_HALF),
      .SUB_LOG2     (SUB_LOG2)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable[i]),
      .cfg_we   (cfg_we),
      .cfg_half (cfg.cfg_half),
      .pending  (pending[i]),
      .usr_clk  (usr_clk[i]),
      .sub_clk  (sub_clk[i]),
      .tick     (tick[i])
    );
  end

endmodule

// File: tb/tb_multi_real_clock_gen.sv
module tb_multi_real_clock_gen;

  localparam int NUM_CH   = 2;
  localparam int CNT_W    = 26;
  localparam int DEF_HALF = 8;
  localparam int SUB_LOG2 = 2;
  localparam int CH_W     = 2;
  localparam int NSEG     = 2 ** SUB_LOG2;

  logic              clk;
  logic              rst;
  logic [NUM_CH-1:0] en;
  logic [NUM_CH-1:0] usr;
  logic [NUM_CH-1:0] sub;
  logic [NUM_CH-1:0] tck;

  multi_real_clock_gen_if #(.CH_W(CH_W), .CNT_W(CNT_W)) cfg_if ();

  multi_real_clock_gen #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_HALF(DEF_HALF),
    .SUB_LOG2(SUB_LOG2), .CH_W(CH_W)
  ) dut (
    .clk(clk), .reset(rst), .enable(en), .cfg(cfg_if),
    .usr_clk(usr), .sub_clk(sub), .tick(tck)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: the phase of each channel is a position inside its current
  // half-period. The sub-clock level is derived arithmetically from that
  // position.
  int m_half   [NUM_CH];
  int m_shadow [NUM_CH];
  int m_pos    [NUM_CH];
  bit m_pend   [NUM_CH];
  bit m_lvl    [NUM_CH];
  bit m_tick   [NUM_CH];
  bit m_err;

  typedef struct {
    logic [NUM_CH-1:0] usr;
    logic [NUM_CH-1:0] sub;
    logic [NUM_CH-1:0] tck;
    logic              err;
    logic              rdy;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic bit sub_of(input int p, input int h);
    int idx;
    idx = p / (h / NSEG);
    if (idx > NSEG - 1) idx = NSEG - 1;
    return (idx % 2) == 1;
  endfunction

  function automatic bit ready_of(input int ch);
    if (ch >= NUM_CH) return 1'b0;
    return !m_pend[ch];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_half[i] = DEF_HALF;
      m_pos[i]  = 0;
      m_pend[i] = 1'b0;
      m_lvl[i]  = 1'b0;
      m_tick[i] = 1'b0;
    end
    m_err = 1'b0;
  endtask

  task automatic model_step(input logic [NUM_CH-1:0] e, input bit v, input int ch, input int h);
    bit rdy, acc, err_n;
    rdy   = ready_of(ch);
    err_n = v && (ch >= NUM_CH || (rdy && h < NSEG));
    acc   = v && rdy && h >= NSEG;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!e[i]) begin
        m_pos[i]  = 0;
        m_lvl[i]  = 1'b0;
        m_tick[i] = 1'b0;
        if (m_pend[i]) begin
          m_half[i] = m_shadow[i];
          m_pend[i] = 1'b0;
        end
        if (acc && ch == i) m_half[i] = h;
      end else begin
        if (m_pos[i] == m_half[i] - 1) begin
          m_pos[i]  = 0;
          m_tick[i] = !m_lvl[i];
          m_lvl[i]  = !m_lvl[i];
          if (m_pend[i]) begin
            m_half[i] = m_shadow[i];
            m_pend[i] = 1'b0;
          end
        end else begin
          m_pos[i]++;
          m_tick[i] = 1'b0;
        end
        if (acc && ch == i) begin
          m_shadow[i] = h;
          m_pend[i]   = 1'b1;
        end
      end
    end
    m_err = err_n;
  endtask

  // Runs one clock cycle. Inputs are driven at the falling edge. The expected
  // outputs for the sample point are queued. The model then advances at the
  // rising edge.
  task automatic cycle(input bit r, input logic [NUM_CH-1:0] e, input bit v,
                       input int ch, input int h);
    exp_t x;
    @(negedge clk);
    rst              = r;
    en               = e;
    cfg_if.cfg_valid = v;
    cfg_if.cfg_ch    = CH_W'(ch);
    cfg_if.cfg_half  = CNT_W'(h);
    if (!r) model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      x.usr[i] = m_lvl[i];
      x.sub[i] = sub_of(m_pos[i], m_half[i]);
      x.tck[i] = m_tick[i];
    end
    x.err = m_err;
    x.rdy = ready_of(ch);
    sb.push_back(x);
    @(posedge clk);
    if (r) model_step(e, v, ch, h);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b1, en, 1'b0, 0, 0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: one sample per cycle, compared against the queued expectation.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk("usr_clk",   32'(usr),              32'(x.usr));
        chk("sub_clk",   32'(sub),              32'(x.sub));
        chk("tick",      32'(tck),              32'(x.tck));
        chk("cfg_err",   32'(cfg_if.cfg_err),   32'(x.err));
        chk("cfg_ready", 32'(cfg_if.cfg_ready), 32'(x.rdy));
      end
    end
  end

  initial begin
    bit found;
    rst              = 1'b0;
    en               = '0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch    = '0;
    cfg_if.cfg_half  = '0;
    model_reset();

    // Reset, then run channel 0 only at the default length.
    for (int k = 0; k < 3; k++) cycle(1'b0, 2'b00, 1'b0, 0, 0);
    cycle(1'b1, 2'b01, 1'b0, 0, 0);
    idle(36);

    // Reprogram channel 0 while it runs. cfg_ready for ch0 stays low until the next wrap.
    cycle(1'b1, en, 1'b1, 0, 12);
    idle(40);

    // Reprogram disabled channel 1, then enable it. The last sub-segment absorbs the remainder.
    cycle(1'b1, en, 1'b1, 1, 6);
    idle(2);
    cycle(1'b1, 2'b11, 1'b0, 0, 0);
    idle(30);

    // Rejected requests: a half-period that is too short, and a nonexistent channel.
    cycle(1'b1, en, 1'b1, 0, 3);
    idle(2);
    cycle(1'b1, en, 1'b1, 2, 10);
    idle(20);

    // Back to 8, then issue a request aligned with the wrap cycle of channel 0.
    cycle(1'b1, en, 1'b1, 0, 8);
    idle(30);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (m_pos[0] == m_half[0] - 1) found = 1'b1;
      else idle(1);
    end
    chk("wrap_align_found", 32'(found), 32'd1);
    cycle(1'b1, en, 1'b1, 0, 10);
    idle(40);

    // Reset mid-period while usr_clk of channel 0 is high.
    cycle(1'b1, en, 1'b1, 0, 8);
    idle(20);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (m_lvl[0] && m_pos[0] == 5) found = 1'b1;
      else idle(1);
    end
    chk("mid_reset_found", 32'(found), 32'd1);
    cycle(1'b0, en, 1'b0, 0, 0);
    cycle(1'b0, en, 1'b0, 0, 0);
    cycle(1'b1, 2'b01, 1'b0, 0, 0);
    idle(20);

    // Randomized traffic: enable changes, requests (valid and invalid), occasional resets.
    for (int k = 0; k < 1500; k++) begin
      bit               r, v;
      logic [NUM_CH-1:0] e;
      int               ch, h;
      r  = ($urandom_range(0, 299) != 0);
      e  = ($urandom_range(0, 39) == 0) ? NUM_CH'($urandom_range(0, 3)) : en;
      v  = ($urandom_range(0, 5) == 0);
      ch = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 1);
      h  = $urandom_range(1, 20);
      cycle(r, e, v, ch, h);
    end

    idle(2);
    @(negedge clk);
    #5;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
